prv_mem_subsys: RTL and testbench
=================================

Name: prv_mem_subsys

Overview:
Memory-side companion for the picorv32 native memory interface. It answers mem_valid/mem_ready transactions from a parametrised word RAM and a small register bank: GPIO plus an interval timer. It drives one bit of the core's irq vector from the timer. It replaces tied-off mem_ready/mem_rdata/irq in core test harnesses and adds configurable wait states.

Parameters:
RAM_WORDS, 4096, RAM depth in 32-bit words; power of two, 16..65536
WAIT_STATES, 1, extra cycles inserted before mem_ready; 0..15
IRQ_NUM, 3, irq vector bit driven by the timer; 3..31
GPIO_W, 8, width of gpio_out and gpio_in; 1..32

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
mem_valid  in  1  core request valid; held until mem_ready
mem_instr  in  1  instruction fetch qualifier; informational only
mem_addr  in  32  byte address; bits [1:0] ignored
mem_wdata  in  32  write data
mem_wstrb  in  4  byte write strobes; 0 = read
mem_ready  out  1  one-cycle acknowledge
mem_rdata  out  32  read data, valid while mem_ready=1
irq  out  32  interrupt vector to core; only bit IRQ_NUM ever set
eoi  in  32  end-of-interrupt from core
gpio_out  out  GPIO_W  GPIO output register
gpio_in  in  GPIO_W  asynchronous GPIO inputs
bus_err  out  1  one-cycle pulse with mem_ready on an unmapped access

Behaviour:
- Reset (resetn low, asynchronous):
  - mem_ready=0, mem_rdata=0, irq=0, gpio_out=0, bus_err=0.
  - Timer CNT=0, CMP=0xFFFFFFFF, CTRL=0, pending=0.
  - FSM goes to IDLE. RAM contents are not reset.
- Address map (word aligned):
  - RAM: 0x0000_0000..4*RAM_WORDS-1.
  - 0x1000_0000 GPIO_OUT, rw.
  - 0x1000_0004 GPIO_IN, ro. Value passes a 2-flop synchroniser and is zero-extended.
  - 0x1000_0008 TIMER_CMP, rw.
  - 0x1000_000C TIMER_CNT, rw; a write loads the counter.
  - 0x1000_0010 TIMER_CTRL. bit0 enable, bit1 autoreload, bit8 pending. Bit8 reads pending; writing 1 to bit8 clears it (W1C).
  - Anything else is unmapped.
- FSM states IDLE, WAIT, ACK:
  - IDLE, mem_valid=1: latch addr/wdata/wstrb. Go to WAIT with wait counter=WAIT_STATES, or straight to ACK when WAIT_STATES=0.
  - WAIT: decrement the counter each cycle; go to ACK when it reaches 1.
  - ACK: mem_ready=1 for exactly one cycle, then IDLE.
  - A request first seen in cycle N is acknowledged in cycle N+1+WAIT_STATES.
  - mem_valid dropping before the acknowledge is a protocol error; the latched request still completes.
- Data path:
  - RAM is read synchronously from the latched address, so data is ready by ACK. Reads ignore wstrb.
  - Writes commit in the ACK cycle, per byte lane by wstrb. Strobes on a register write that are not all 1111 still write the full word.
  - Unmapped access: read data=0, writes dropped, bus_err=1 during ACK. The access is always acknowledged; the block never hangs the core.
- Timer, when enabled:
  - CNT increments by 1 per cycle, modulo 2^32.
  - When CNT==CMP, pending is set. With autoreload, CNT becomes 0 on the next cycle; without it, counting continues.
  - irq[IRQ_NUM]=pending (registered); all other irq bits are 0.
  - Pending clears on the W1C write or on eoi[IRQ_NUM]=1.
- Simultaneous events:
  - Bus write to TIMER_CNT and an increment in the same cycle: the write wins.
  - Match and clear (W1C or eoi) in the same cycle: set wins.
  - A write that disables the timer takes effect the next cycle.

Optional Feature:
PRV_MEM_TIMER_EN.
- Defined: timer registers and irq generation exist as described.
- Undefined: no timer logic is built. 0x1000_0008..0x1000_0010 become unmapped (bus_err on access), irq is constant 0, and eoi is ignored.

Test Plan:
- Reset then idle: resetn low for 3 cycles -> all outputs 0; gpio_out=0x00 with GPIO_W=8.
- WAIT_STATES=2: write 0xCAFEBABE to 0x40 with wstrb=1111 -> mem_ready on the 3rd cycle after mem_valid. Then write wstrb=0010, wdata=0x0000_1200, read 0x40 -> rdata 0xCAFE12BE.
- Unmapped: read 0x2000_0000 -> mem_ready with rdata=0 and bus_err=1 in the same cycle, for one cycle.
- GPIO: gpio_in=0xA5 -> read 0x1000_0004 returns 0x000000A5. Write 0x3C to 0x1000_0000 -> gpio_out=0x3C.
- Timer autoreload: CMP=4, CTRL=0x3 -> irq[3] rises 5 cycles after enable and CNT wraps to 0. eoi[3] pulse clears irq[3]. A match coinciding with a W1C of 0x100 leaves pending=1.
- Async reset mid-transaction: resetn low during WAIT -> mem_ready never asserts, FSM is IDLE. After release, a new read of the same RAM word returns the pre-reset contents.

Source files
------------

// File: rtl/prv_mem_subsys.sv
// Memory-side responder for the picorv32 native interface: word RAM, GPIO, and an optional
// interval timer driving irq[IRQ_NUM]. Define PRV_MEM_TIMER_EN to build the timer.
module prv_mem_subsys #(
  parameter int RAM_WORDS   = 4096,
  parameter int WAIT_STATES = 1,
  parameter int IRQ_NUM     = 3,
  parameter int GPIO_W      = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              mem_valid,
  input  logic              mem_instr,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_wstrb,
  output logic              mem_ready,
  output logic [31:0]       mem_rdata,
  output logic [31:0]       irq,
  input  logic [31:0]       eoi,
  output logic [GPIO_W-1:0] gpio_out,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic              bus_err
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam logic [29:0] A_GPIO_OUT = 30'h0400_0000;
  localparam logic [29:0] A_GPIO_IN  = 30'h0400_0001;
  localparam logic [29:0] A_CMP      = 30'h0400_0002;
  localparam logic [29:0] A_CNT      = 30'h0400_0003;
  localparam logic [29:0] A_CTRL     = 30'h0400_0004;
`ifdef PRV_MEM_TIMER_EN
  localparam bit TIMER_EN = 1'b1;
`else
  localparam bit TIMER_EN = 1'b0;
`endif

  function automatic logic is_ram(input logic [31:0] a);
    return a[31:AW+2] == '0;
  endfunction

  function automatic logic is_mapped(input logic [31:0] a);
    return is_ram(a) || (a[31:2] == A_GPIO_OUT) || (a[31:2] == A_GPIO_IN) ||
           (TIMER_EN && ((a[31:2] == A_CMP) || (a[31:2] == A_CNT) || (a[31:2] == A_CTRL)));
  endfunction

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t      state;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [3:0]  wstrb_reg;
  logic [3:0]  wait_cnt;

  // The request is latched once; a core that drops mem_valid early still gets its acknowledge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      mem_ready <= 1'b0;
      bus_err   <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      wstrb_reg <= '0;
      wait_cnt  <= '0;
    end else begin
      mem_ready <= 1'b0;
      bus_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_valid) begin
            addr_reg  <= mem_addr;
            wdata_reg <= mem_wdata;
            wstrb_reg <= mem_wstrb;
            wait_cnt  <= 4'(WAIT_STATES);
            if (WAIT_STATES == 0) begin
              state     <= ACK;
              mem_ready <= 1'b1;
              bus_err   <= !is_mapped(mem_addr);
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (wait_cnt <= 4'd1) begin
            state     <= ACK;
            mem_ready <= 1'b1;
            bus_err   <= !is_mapped(addr_reg);
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  logic [29:0]   word;
  logic          reg_wr;
  logic          ram_we;
  logic [AW-1:0] rd_idx;
  logic [31:0]   ram_rdata;

  assign word   = addr_reg[31:2];
  assign reg_wr = mem_ready && (wstrb_reg != 4'b0);
  assign ram_we = reg_wr && is_ram(addr_reg);
  // IDLE reads from the live address so zero-wait-state reads still have data at ACK.
  assign rd_idx = (state == IDLE) ? mem_addr[AW+1:2] : addr_reg[AW+1:2];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [RAM_WORDS];
      logic [7:0] q;
      always_ff @(posedge clk) begin
        if (ram_we && wstrb_reg[gi])
          mem[addr_reg[AW+1:2]] <= wdata_reg[8*gi +: 8];
        q <= mem[rd_idx];
      end
      assign ram_rdata[8*gi +: 8] = q;
    end
  endgenerate

  logic [GPIO_W-1:0] gpio_meta;
  logic [GPIO_W-1:0] gpio_sync;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      gpio_out  <= '0;
      gpio_meta <= '0;
      gpio_sync <= '0;
    end else begin
      gpio_meta <= gpio_in;
      gpio_sync <= gpio_meta;
      if (reg_wr && word == A_GPIO_OUT)
        gpio_out <= wdata_reg[GPIO_W-1:0];
    end
  end

`ifdef PRV_MEM_TIMER_EN
  logic [31:0] cnt_reg;
  logic [31:0] cmp_reg;
  logic        en_reg;
  logic        ar_reg;
  logic        pending_reg;
  logic        match;

  assign match = en_reg && (cnt_reg == cmp_reg);

  // Priorities: bus write beats increment, match beats any clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_reg     <= '0;
      cmp_reg     <= '1;
      en_reg      <= 1'b0;
      ar_reg      <= 1'b0;
      pending_reg <= 1'b0;
    end else begin
      if (reg_wr && word == A_CNT)
        cnt_reg <= wdata_reg;
      else if (en_reg)
        cnt_reg <= (match && ar_reg) ? '0 : cnt_reg + 32'd1;
      if (reg_wr && word == A_CMP)
        cmp_reg <= wdata_reg;
      if (reg_wr && word == A_CTRL) begin
        en_reg <= wdata_reg[0];
        ar_reg <= wdata_reg[1];
      end
      if (match)
        pending_reg <= 1'b1;
      else if ((reg_wr && word == A_CTRL && wdata_reg[8]) || eoi[IRQ_NUM])
        pending_reg <= 1'b0;
    end
  end

  assign irq = 32'(pending_reg) << IRQ_NUM;
`else
  assign irq = '0;
`endif

  logic [31:0] reg_rdata;

  always_comb begin
    reg_rdata = '0;
    case (word)
      A_GPIO_OUT: reg_rdata[GPIO_W-1:0] = gpio_out;
      A_GPIO_IN:  reg_rdata[GPIO_W-1:0] = gpio_sync;
`ifdef PRV_MEM_TIMER_EN
      A_CMP:      reg_rdata = cmp_reg;
      A_CNT:      reg_rdata = cnt_reg;
      A_CTRL:     reg_rdata = {23'b0, pending_reg, 6'b0, ar_reg, en_reg};
`endif
      default:    reg_rdata = '0;
    endcase
  end

  assign mem_rdata = !mem_ready ? '0 : (is_ram(addr_reg) ? ram_rdata : reg_rdata);

  logic unused_ok;
  assign unused_ok = ^{mem_instr, mem_addr, addr_reg, eoi};

endmodule

// File: tb/tb_prv_mem_subsys.sv
// Directed bench for prv_mem_subsys (WAIT_STATES=2, RAM_WORDS=256); timer checks follow PRV_MEM_TIMER_EN.
module tb_prv_mem_subsys;

  logic        clk = 1'b0;
  logic        resetn;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] irq;
  logic [31:0] eoi;
  logic [7:0]  gpio_out;
  logic [7:0]  gpio_in;
  logic        bus_err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  prv_mem_subsys #(
    .RAM_WORDS(256), .WAIT_STATES(2), .IRQ_NUM(3), .GPIO_W(8)
  ) dut (
    .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_instr(mem_instr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .irq(irq), .eoi(eoi),
    .gpio_out(gpio_out), .gpio_in(gpio_in), .bus_err(bus_err)
  );

  // Called at posedge+1; returns at posedge+1 of the cycle after the acknowledge.
  task automatic bus_xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [31:0] rd, output logic be, output int lat);
    mem_valid = 1'b1; mem_addr = a; mem_wdata = d; mem_wstrb = s;
    lat = 0; rd = '0; be = 1'b0;
    while (1) begin
      @(negedge clk);
      if (mem_ready) begin
        rd = mem_rdata; be = bus_err;
        break;
      end
      lat++;
      if (lat > 20) begin
        vectors++; miscompares++;
        $display("FAIL ack_timeout addr=%h got no mem_ready want ack within 20 cycles", a);
        break;
      end
    end
    @(posedge clk); #1;
    mem_valid = 1'b0; mem_wstrb = 4'b0;
    $display("xfer addr=%h wdata=%h wstrb=%b rdata=%h bus_err=%b lat=%0d", a, d, s, rd, be, lat);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (mem_ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready got %b want 0", mem_ready); end
    vectors++; if (mem_rdata !== 32'h0) begin miscompares++; $display("FAIL rst_rdata got %h want 0", mem_rdata); end
    vectors++; if (irq !== 32'h0) begin miscompares++; $display("FAIL rst_irq got %h want 0", irq); end
    vectors++; if (gpio_out !== 8'h00) begin miscompares++; $display("FAIL rst_gpio_out got %h want 00", gpio_out); end
    vectors++; if (bus_err !== 1'b0) begin miscompares++; $display("FAIL rst_bus_err got %b want 0", bus_err); end
    resetn = 1'b1;
    @(posedge clk); #1;
    vectors++; if (mem_ready !== 1'b0 || bus_err !== 1'b0) begin miscompares++; $display("FAIL idle_outputs got ready=%b err=%b want 0/0", mem_ready, bus_err); end
  endtask

  task automatic test_ram_wait();
    logic [31:0] rd; logic be; int lat;
    bus_xfer(32'h40, 32'hCAFEBABE, 4'b1111, rd, be, lat);
    vectors++; if (lat !== 3) begin miscompares++; $display("FAIL wr_latency got %0d want 3", lat); end
    vectors++; if (be !== 1'b0) begin miscompares++; $display("FAIL wr_bus_err got %b want 0", be); end
    bus_xfer(32'h40, 32'h0000_1200, 4'b0010, rd, be, lat);
    bus_xfer(32'h40, 32'h0, 4'b0000, rd, be, lat);
    vectors++; if (rd !== 32'hCAFE12BE) begin miscompares++; $display("FAIL byte_lane_rd got %h want cafe12be", rd); end
    vectors++; if (lat !== 3) begin miscompares++; $display("FAIL rd_latency got %0d want 3", lat); end
    bus_xfer(32'h3FC, 32'h1357_9BDF, 4'b1111, rd, be, lat);
    bus_xfer(32'h3FC, 32'h0, 4'b0000, rd, be, lat);
    vectors++; if (rd !== 32'h1357_9BDF || be !== 1'b0) begin miscompares++; $display("FAIL last_word got %h err=%b want 13579bdf err=0", rd, be); end
  endtask

  task automatic test_unmapped();
    logic [31:0] rd; logic be; int lat;
    bus_xfer(32'h2000_0000, 32'h0, 4'b0000, rd, be, lat);
    vectors++; if (rd !== 32'h0 || be !== 1'b1) begin miscompares++; $display("FAIL unmapped_rd got %h err=%b want 0 err=1", rd, be); end
    vectors++; if (lat !== 3) begin miscompares++; $display("FAIL unmapped_latency got %0d want 3", lat); end
    vectors++; if (bus_err !== 1'b0 || mem_ready !== 1'b0) begin miscompares++; $display("FAIL err_one_cycle got err=%b ready=%b want 0/0", bus_err, mem_ready); end
    bus_xfer(32'h0, 32'h1111_1111, 4'b1111, rd, be, lat);
    bus_xfer(32'h400, 32'hDEAD_BEEF, 4'b1111, rd, be, lat);
    vectors++; if (be !== 1'b1) begin miscompares++; $display("FAIL ram_end_err got %b want 1", be); end
    bus_xfer(32'h0, 32'h0, 4'b0000, rd, be, lat);
    vectors++; if (rd !== 32'h1111_1111) begin miscompares++; $display("FAIL no_alias got %h want 11111111", rd); end
  endtask

  task automatic test_gpio();
    logic [31:0] rd; logic be; int lat;
    gpio_in = 8'hA5;
    repeat (3) @(posedge clk);
    #1;
    bus_xfer(32'h1000_0004, 32'h0, 4'b0000, rd, be, lat);
    vectors++; if (rd !== 32'h0000_00A5 || be !== 1'b0) begin miscompares++; $display("FAIL gpio_in got %h err=%b want 000000a5 err=0", rd, be); end
    bus_xfer(32'h1000_0000, 32'hFFFF_FF3C, 4'b0001, rd, be, lat);
    vectors++; if (gpio_out !== 8'h3C) begin miscompares++; $display("FAIL gpio_out got %h want 3c", gpio_out); end
    bus_xfer(32'h1000_0000, 32'h0, 4'b0000, rd, be, lat);
    vectors++; if (rd !== 32'h0000_003C) begin miscompares++; $display("FAIL gpio_out_rd got %h want 0000003c", rd); end
    bus_xfer(32'h1000_0014, 32'h0, 4'b0000, rd, be, lat);
    vectors++; if (be !== 1'b1 || rd !== 32'h0) begin miscompares++; $display("FAIL past_regs got %h err=%b want 0 err=1", rd, be); end
  endtask

`ifdef PRV_MEM_TIMER_EN
  task automatic test_timer();
    logic [31:0] rd; logic be; int lat; int rise_k;
    bus_xfer(32'h1000_0008, 32'h0, 4'b0000, rd, be, lat);
    vectors++; if (rd !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL cmp_reset got %h want ffffffff", rd); end
    bus_xfer(32'h1000_0010, 32'h0, 4'b0000, rd, be, lat);
    vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL ctrl_reset got %h want 0", rd); end
    bus_xfer(32'h1000_0008, 32'h4, 4'b1111, rd, be, lat);
    bus_xfer(32'h1000_0010, 32'h3, 4'b1111, rd, be, lat);
    rise_k = 0;
    for (int k = 1; k <= 10; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      if (irq[3]) begin rise_k = k; break; end
    end
    vectors++; if (rise_k !== 6) begin miscompares++; $display("FAIL irq_rise got cycle %0d want 6", rise_k); end
    vectors++; if (irq !== 32'h8) begin miscompares++; $display("FAIL irq_vector got %h want 00000008", irq); end
    bus_xfer(32'h1000_000C, 32'h0, 4'b0000, rd, be, lat);
    vectors++; if (rd !== 32'h3) begin miscompares++; $display("FAIL autoreload_cnt got %h want 3", rd); end
    bus_xfer(32'h1000_0010, 32'h0, 4'b1111, rd, be, lat);
    vectors++; if (irq !== 32'h8) begin miscompares++; $display("FAIL pending_hold got %h want 8", irq); end
    eoi = 32'h8;
    @(posedge clk); #1;
    eoi = 32'h0;
    vectors++; if (irq !== 32'h0) begin miscompares++; $display("FAIL eoi_clear got %h want 0", irq); end
    bus_xfer(32'h1000_000C, 32'h1234_5678, 4'b1111, rd, be, lat);
    bus_xfer(32'h1000_000C, 32'h0, 4'b0000, rd, be, lat);
    vectors++; if (rd !== 32'h1234_5678) begin miscompares++; $display("FAIL cnt_load got %h want 12345678", rd); end
    bus_xfer(32'h1000_000C, 32'h0, 4'b1111, rd, be, lat);
    bus_xfer(32'h1000_0008, 32'h3, 4'b1111, rd, be, lat);
    bus_xfer(32'h1000_0010, 32'h3, 4'b1111, rd, be, lat);
    vectors++; if (irq !== 32'h0) begin miscompares++; $display("FAIL pre_match_irq got %h want 0", irq); end
    // W1C lands in the same cycle CNT hits CMP=3
    bus_xfer(32'h1000_0010, 32'h103, 4'b1111, rd, be, lat);
    vectors++; if (irq !== 32'h8) begin miscompares++; $display("FAIL set_wins got %h want 8", irq); end
    bus_xfer(32'h1000_0010, 32'h0, 4'b1111, rd, be, lat);
    bus_xfer(32'h1000_0010, 32'h100, 4'b1111, rd, be, lat);
    vectors++; if (irq !== 32'h0) begin miscompares++; $display("FAIL w1c_clear got %h want 0", irq); end
    bus_xfer(32'h1000_0010, 32'h0, 4'b0000, rd, be, lat);
    vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL ctrl_final got %h want 0", rd); end
  endtask
`else
  task automatic test_timer();
    logic [31:0] rd; logic be; int lat;
    bus_xfer(32'h1000_0008, 32'h0, 4'b0000, rd, be, lat);
    vectors++; if (be !== 1'b1 || rd !== 32'h0) begin miscompares++; $display("FAIL cmp_unmapped got %h err=%b want 0 err=1", rd, be); end
    bus_xfer(32'h1000_000C, 32'h0, 4'b0000, rd, be, lat);
    vectors++; if (be !== 1'b1) begin miscompares++; $display("FAIL cnt_unmapped got err=%b want 1", be); end
    bus_xfer(32'h1000_0010, 32'h3, 4'b1111, rd, be, lat);
    vectors++; if (be !== 1'b1) begin miscompares++; $display("FAIL ctrl_unmapped got err=%b want 1", be); end
    eoi = 32'h8;
    repeat (10) @(posedge clk);
    #1;
    eoi = 32'h0;
    vectors++; if (irq !== 32'h0) begin miscompares++; $display("FAIL irq_const got %h want 0", irq); end
  endtask
`endif

  task automatic test_async_reset();
    logic [31:0] rd; logic be; int lat; int seen;
    bus_xfer(32'h80, 32'h5A5A_5A5A, 4'b1111, rd, be, lat);
    mem_valid = 1'b1; mem_addr = 32'h80; mem_wstrb = 4'b0000;
    @(posedge clk); #3;
    resetn = 1'b0;
    #1;
    vectors++; if (gpio_out !== 8'h00) begin miscompares++; $display("FAIL async_gpio got %h want 00", gpio_out); end
    seen = 0;
    repeat (2) begin @(negedge clk); if (mem_ready) seen++; end
    @(posedge clk); #1;
    resetn = 1'b1; mem_valid = 1'b0;
    repeat (4) begin @(negedge clk); if (mem_ready) seen++; end
    vectors++; if (seen !== 0) begin miscompares++; $display("FAIL aborted_ack got %0d acks want 0", seen); end
    @(posedge clk); #1;
    bus_xfer(32'h80, 32'h0, 4'b0000, rd, be, lat);
    vectors++; if (rd !== 32'h5A5A_5A5A) begin miscompares++; $display("FAIL ram_retained got %h want 5a5a5a5a", rd); end
    vectors++; if (lat !== 3) begin miscompares++; $display("FAIL post_reset_lat got %0d want 3", lat); end
  endtask

  initial begin
    mem_valid = 1'b0; mem_instr = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
    eoi = '0; gpio_in = '0;
    test_reset();
    test_ram_wait();
    test_unmapped();
    test_gpio();
    test_timer();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got no finish want finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
